// File: rtl/pingpong_buf.sv
// Two-bank ping-pong buffer: producer fills one bank while consumer drains the other; read data is registered (1 cycle).
// Backpressure via i_full_n / t_empty_n; optional sticky err port under PINGPONG_BUF_ERR_EN.
module pingpong_buf #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 3
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [AWIDTH-1:0] i_address0,
  input  logic              i_ce0,
  input  logic              i_we0,
  input  logic [DWIDTH-1:0] i_d0,
  input  logic              i_write,
  output logic              i_full_n,
  input  logic [AWIDTH-1:0] t_address0,
  input  logic              t_ce0,
  output logic [DWIDTH-1:0] t_q0,
  input  logic              t_read,
  output logic              t_empty_n
`ifdef PINGPONG_BUF_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int DEPTH = 1 << AWIDTH;

  // Both banks live in one array; the bank select is the top address bit.
  logic [DWIDTH-1:0] mem [0:2*DEPTH-1];
  logic [1:0]        full;
  logic              wr_sel;
  logic              rd_sel;
  logic              wr_en;
  logic              commit;
  logic              rls;

  assign i_full_n  = ~full[wr_sel];
  assign t_empty_n = full[rd_sel];
  assign wr_en     = i_ce0 & i_we0 & i_full_n;
  assign commit    = i_write & i_full_n;
  assign rls       = t_read & t_empty_n;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst && wr_en) begin
      mem[{wr_sel, i_address0}] <= i_d0;
    end
  end

  // Commit and release never target the same bank: when the selects match,
  // either both banks are empty (no release) or both are full (no commit).
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      t_q0   <= '0;
    end else begin
      if (commit) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end
      if (rls) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
      if (t_ce0) begin
        t_q0 <= mem[{rd_sel, t_address0}];
      end
    end
  end

`ifdef PINGPONG_BUF_ERR_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      err <= 1'b0;
    end else if ((i_ce0 & i_we0 & ~i_full_n) | (i_write & ~i_full_n) | (t_read & ~t_empty_n)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pingpong_buf.sv
// Directed bench for pingpong_buf: read data checked by a scoreboard monitor, flags checked inline.
module tb_pingpong_buf;
  localparam int DWIDTH = 32;
  localparam int AWIDTH = 3;

  logic              ap_clk = 1'b0;
  logic              ap_rst = 1'b1;
  logic [AWIDTH-1:0] i_address0 = '0;
  logic              i_ce0 = 1'b0;
  logic              i_we0 = 1'b0;
  logic [DWIDTH-1:0] i_d0 = '0;
  logic              i_write = 1'b0;
  logic              i_full_n;
  logic [AWIDTH-1:0] t_address0 = '0;
  logic              t_ce0 = 1'b0;
  logic [DWIDTH-1:0] t_q0;
  logic              t_read = 1'b0;
  logic              t_empty_n;
`ifdef PINGPONG_BUF_ERR_EN
  logic              err;
`endif

  int checks = 0;
  int errors = 0;
  logic [DWIDTH-1:0] exp_q[$];
  logic pend = 1'b0;

  pingpong_buf #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .i_address0(i_address0), .i_ce0(i_ce0), .i_we0(i_we0), .i_d0(i_d0),
    .i_write(i_write), .i_full_n(i_full_n),
    .t_address0(t_address0), .t_ce0(t_ce0), .t_q0(t_q0),
    .t_read(t_read), .t_empty_n(t_empty_n)
`ifdef PINGPONG_BUF_ERR_EN
    , .err(err)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: a read accepted at an edge presents data after that edge.
  always @(posedge ap_clk) pend <= t_ce0 && !ap_rst;

  always @(negedge ap_clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual=%0h expected=none", t_q0);
      end else begin
        chk("rd_data", {32'd0, t_q0}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [DWIDTH-1:0] d);
    i_ce0 = 1'b1; i_we0 = 1'b1; i_address0 = AWIDTH'(addr); i_d0 = d;
    step();
    i_ce0 = 1'b0; i_we0 = 1'b0;
  endtask

  task automatic rd(input int addr, input logic [DWIDTH-1:0] e);
    t_ce0 = 1'b1; t_address0 = AWIDTH'(addr);
    exp_q.push_back(e);
    step();
    t_ce0 = 1'b0;
  endtask

  task automatic pulse(input bit w, input bit r);
    i_write = w; t_read = r;
    step();
    i_write = 1'b0; t_read = 1'b0;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
  endtask

  initial begin
    step();
    step();
    ap_rst = 1'b0;
    chk("rst_full_n", {63'd0, i_full_n}, 64'd1);
    chk("rst_empty_n", {63'd0, t_empty_n}, 64'd0);
    chk("rst_q0", {32'd0, t_q0}, 64'd0);

    // Basic fill, commit, drain of bank 0
    for (int i = 0; i < 5; i++) wr(i, DWIDTH'(i + 1));
    pulse(1'b1, 1'b0);
    chk("commit_empty_n", {63'd0, t_empty_n}, 64'd1);
    chk("commit_full_n", {63'd0, i_full_n}, 64'd1);
    for (int i = 0; i < 5; i++) rd(i, DWIDTH'(i + 1));
    step();
    step();
    chk("q0_hold", {32'd0, t_q0}, 64'd5);

    // Reset with a committed bank discards it and clears t_q0
    do_reset();
    chk("mid_rst_empty_n", {63'd0, t_empty_n}, 64'd0);
    chk("mid_rst_full_n", {63'd0, i_full_n}, 64'd1);
    chk("mid_rst_q0", {32'd0, t_q0}, 64'd0);

    // Fill both banks (full depth, wrapping addresses)
    for (int i = 0; i < 8; i++) wr(i, DWIDTH'(10 + i));
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) wr(i, DWIDTH'(20 + i));
    pulse(1'b1, 1'b0);
    chk("both_full_full_n", {63'd0, i_full_n}, 64'd0);
    chk("both_full_empty_n", {63'd0, t_empty_n}, 64'd1);
    wr(0, 32'hDEAD);
    pulse(1'b1, 1'b0);
    chk("ignored_commit_full_n", {63'd0, i_full_n}, 64'd0);
    rd(0, 32'd10);
    rd(3, 32'd13);

    // Simultaneous commit (blocked) and release while both full
    pulse(1'b1, 1'b1);
    chk("sim_full_n", {63'd0, i_full_n}, 64'd1);
    chk("sim_empty_n", {63'd0, t_empty_n}, 64'd1);
    rd(0, 32'd20);
    // Release bank 1: both empty, selects both point at bank 0
    pulse(1'b0, 1'b1);
    chk("both_empty_empty_n", {63'd0, t_empty_n}, 64'd0);
    chk("both_empty_full_n", {63'd0, i_full_n}, 64'd1);
    // Same-cycle write and read of bank 0 addr 0 returns old data
    i_ce0 = 1'b1; i_we0 = 1'b1; i_address0 = 3'd0; i_d0 = 32'd30;
    t_ce0 = 1'b1; t_address0 = 3'd0;
    exp_q.push_back(32'd10);
    step();
    i_ce0 = 1'b0; i_we0 = 1'b0; t_ce0 = 1'b0;
    rd(0, 32'd30);
    pulse(1'b1, 1'b0);
    rd(1, 32'd11);

    // Distinct-bank commit and release in the same cycle
    wr(0, 32'd40);
    pulse(1'b1, 1'b1);
    chk("swap_full_n", {63'd0, i_full_n}, 64'd1);
    chk("swap_empty_n", {63'd0, t_empty_n}, 64'd1);
    rd(0, 32'd40);

    // Release while empty
    do_reset();
    pulse(1'b0, 1'b1);
    chk("bad_rls_empty_n", {63'd0, t_empty_n}, 64'd0);
    chk("bad_rls_full_n", {63'd0, i_full_n}, 64'd1);
`ifdef PINGPONG_BUF_ERR_EN
    chk("err_set", {63'd0, err}, 64'd1);
`endif
    wr(2, 32'd77);
    pulse(1'b1, 1'b0);
    chk("after_bad_empty_n", {63'd0, t_empty_n}, 64'd1);
    rd(2, 32'd77);
    step();
`ifdef PINGPONG_BUF_ERR_EN
    chk("err_sticky", {63'd0, err}, 64'd1);
    do_reset();
    chk("err_clr", {63'd0, err}, 64'd0);
`endif
    step();
    step();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
